block_read_data: RTL and testbench

Read-side counterpart of the sort datapath's RAM write path: on a rising edge of a read request it issues one single-cycle read strobe to the data RAM, waits the RAM's fixed read latency, and captures the returned word into one of two destination registers (key or temp-min), selected at request time. It sits between the sort control FSM and the data RAM read port; the RAM address is driven elsewhere and is held stable by the controller while `o_busy` is high.

---
 rtl/sort_pkg.sv | 14 +
 rtl/ram_read_data.sv | 83 ++++++++
 rtl/block_read_data.sv | 63 ++++++
 tb/tb_block_read_data.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and limits for the sort datapath RAM access blocks.
package sort_pkg;

  localparam int RD_LATENCY_MAX = 15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } rd_state_e;

endpackage

// File: rtl/ram_read_data.sv
// Read sequencer for the data RAM: issues one strobe, waits the fixed read
// latency and flags the cycle in which the RAM word must be captured.
module ram_read_data
  import sort_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic rd_strobe,
  output logic busy,
  output logic capt,
  output logic done
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_latency_check
    $error("ram_read_data: RD_LATENCY must be within 1..RD_LATENCY_MAX");
  end

  rd_state_e        state;
  logic [CNT_W-1:0] cnt;

  // Sequencer FSM; all outputs are decoded one cycle early so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_strobe <= 1'b0;
      busy      <= 1'b0;
      capt      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      capt      <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            rd_strobe <= 1'b1;
            busy      <= 1'b1;
          end
        end
        REQ: begin
          if (RD_LATENCY == 1) begin
            state <= CAPT;
            capt  <= 1'b1;
          end else begin
            cnt   <= CNT_W'(RD_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          // Counter saturates at zero so a corrupted value cannot wrap around.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
          if (cnt <= CNT_W'(1)) begin
            state <= CAPT;
            capt  <= 1'b1;
          end
        end
        CAPT: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/block_read_data.sv
// Read side of the sort datapath: edge-triggered RAM read whose result lands
// in either the key or the temp-min register.
module block_read_data
  import sort_pkg::*;
#(
  parameter int SIZE_DATA  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rd_en,
  input  logic                 i_sel_rd,
  input  logic [SIZE_DATA-1:0] i_data_ram,
  output logic                 o_rd_en,
  output logic [SIZE_DATA-1:0] o_data_key,
  output logic [SIZE_DATA-1:0] o_temp_min,
  output logic                 o_busy,
  output logic                 o_done
);

  logic r_rd_en_d;
  logic r_sel;
  logic start;
  logic capt;

  // The sequencer reports busy in every state except IDLE.
  assign start = i_rd_en & ~r_rd_en_d & ~o_busy;

  // Edge detect, destination latch and capture demux.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_en_d  <= 1'b0;
      r_sel      <= 1'b0;
      o_data_key <= '0;
      o_temp_min <= '0;
    end else begin
      r_rd_en_d <= i_rd_en;
      if (start) begin
        r_sel <= i_sel_rd;
      end
      if (capt) begin
        if (r_sel) begin
          o_temp_min <= i_data_ram;
        end else begin
          o_data_key <= i_data_ram;
        end
      end
    end
  end

  ram_read_data #(
    .RD_LATENCY(RD_LATENCY)
  ) u_ram_read_data (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (start),
    .rd_strobe(o_rd_en),
    .busy     (o_busy),
    .capt     (capt),
    .done     (o_done)
  );

endmodule

// File: tb/tb_block_read_data.sv
// Bench for block_read_data at read latencies 1 and 3, driven by shared
// stimulus; a timeline reference model feeds per-instance scoreboards.
module tb_block_read_data;

  typedef struct {
    logic       sel;
    logic [7:0] word;
    int         due;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic       sel;
  logic [7:0] ram0, ram1;
  logic       rd0, busy0, done0, rd1, busy1, done1;
  logic [7:0] key0, tmin0, key1, tmin1;

  always #5 clk = ~clk;

  block_read_data #(.SIZE_DATA(8), .RD_LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_sel_rd(sel), .i_data_ram(ram0),
    .o_rd_en(rd0), .o_data_key(key0), .o_temp_min(tmin0), .o_busy(busy0), .o_done(done0)
  );

  block_read_data #(.SIZE_DATA(8), .RD_LATENCY(3)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_sel_rd(sel), .i_data_ram(ram1),
    .o_rd_en(rd1), .o_data_key(key1), .o_temp_min(tmin1), .o_busy(busy1), .o_done(done1)
  );

  int         checks = 0;
  int         errors = 0;
  int         n = 0;
  int         lat [2] = '{1, 3};
  int         t_start [2] = '{-1, -1};
  logic       prev [2] = '{1'b0, 1'b0};
  logic [7:0] mkey [2] = '{8'h00, 8'h00};
  logic [7:0] mtmin [2] = '{8'h00, 8'h00};
  logic [7:0] cur_word [2] = '{8'h00, 8'h00};
  logic       cur_sel [2] = '{1'b0, 1'b0};
  txn_t       q0[$];
  txn_t       q1[$];

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat%0d cycle %0d: got %0h expected %0h", name, lat[d], n, act, exp);
    end
  endtask

  // Reference model per instance: a transaction started at T strobes in T+1,
  // is busy T+1..T+2+L, completes in T+2+L; the RAM returns its word in T+1+L.
  task automatic step(input int d, input logic ro, input logic bsy, input logic dn,
                      input logic [7:0] key, input logic [7:0] tmin);
    txn_t       t;
    int         L;
    bit         act;
    logic [7:0] data;
    L   = lat[d];
    act = (t_start[d] >= 0);
    if (act && n == t_start[d] + 2 + L) begin
      if (cur_sel[d]) mtmin[d] = cur_word[d];
      else mkey[d] = cur_word[d];
    end
    check("rd_strobe", d, 32'(ro), 32'(act && n == t_start[d] + 1));
    check("busy", d, 32'(bsy), 32'(act && n >= t_start[d] + 1 && n <= t_start[d] + 2 + L));
    check("done", d, 32'(dn), 32'(act && n == t_start[d] + 2 + L));
    check("key", d, 32'(key), 32'(mkey[d]));
    check("temp_min", d, 32'(tmin), 32'(mtmin[d]));
    if (dn === 1'b1) begin
      if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done lat%0d cycle %0d: got done with empty scoreboard", L, n);
      end else begin
        t = (d == 0) ? q0.pop_front() : q1.pop_front();
        check("sb_done_cycle", d, 32'(n), 32'(t.due));
        check("sb_data", d, 32'(t.sel ? tmin : key), 32'(t.word));
      end
    end
    if (rst) begin
      t_start[d] = -1;
      prev[d]    = 1'b0;
      mkey[d]    = 8'h00;
      mtmin[d]   = 8'h00;
      if (d == 0) q0.delete();
      else q1.delete();
    end else begin
      if (rd_en && !prev[d] && !(act && n <= t_start[d] + 2 + L)) begin
        t_start[d]  = n;
        cur_sel[d]  = sel;
        cur_word[d] = 8'($urandom);
        t.sel  = sel;
        t.word = cur_word[d];
        t.due  = n + 2 + L;
        if (d == 0) q0.push_back(t);
        else q1.push_back(t);
      end
      prev[d] = rd_en;
    end
    data = (t_start[d] >= 0 && n == t_start[d] + 1 + L) ? cur_word[d] : ~cur_word[d];
    if (d == 0) ram0 = data;
    else ram1 = data;
  endtask

  // Monitor and RAM model, evaluated mid-cycle.
  always @(negedge clk) begin
    step(0, rd0, busy0, done0, key0, tmin0);
    step(1, rd1, busy1, done1, key1, tmin1);
    n++;
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    rd_en = 1'b0;
    sel   = 1'b0;
    ram0  = 8'h00;
    ram1  = 8'h00;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    // Basic read into key, then temp-min followed by key.
    rd_en = 1'b1; cyc(1); rd_en = 1'b0; cyc(8);
    sel = 1'b1; rd_en = 1'b1; cyc(1); rd_en = 1'b0; cyc(8);
    sel = 1'b0; rd_en = 1'b1; cyc(1); rd_en = 1'b0; cyc(8);
    // Level held high with an extra edge while busy.
    rd_en = 1'b1; cyc(1); rd_en = 1'b0; cyc(1); rd_en = 1'b1; cyc(9); rd_en = 1'b0; cyc(8);
    // Select toggled after the start cycle.
    sel = 1'b0; rd_en = 1'b1; cyc(1); sel = 1'b1; rd_en = 1'b0; cyc(1); sel = 1'b0; cyc(1);
    sel = 1'b1; cyc(6);
    // Reset mid-transaction, request high in the first cycle after release.
    rd_en = 1'b1; cyc(1); rd_en = 1'b0; cyc(1); rst = 1'b1; cyc(1);
    rst = 1'b0; rd_en = 1'b1; cyc(1); rd_en = 1'b0; cyc(8);
    // Reset coincident with a rising edge.
    rst = 1'b1; rd_en = 1'b1; cyc(1); rst = 1'b0; rd_en = 1'b0; cyc(4);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rd_en = ($urandom_range(0, 3) == 0);
      sel   = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 79) == 0);
      cyc(1);
    end
    rst = 1'b0; rd_en = 1'b0;
    cyc(10);
    check("sb_empty", 0, 32'(q0.size()), 32'd0);
    check("sb_empty", 1, 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
